// File: rtl/vga_pixel_stream.sv
// Pixel-stream consumer behind vga_sync_gen: locks a valid/ready {R,G,B} stream to the raster and drives the VGA pins.
// Optional build macro VGA_PIXEL_STREAM_UNDERFLOW_COUNT_EN adds a saturating 16-bit underflow event counter port.
module vga_pixel_stream #(
  parameter int COLOR_W = 4,
  parameter int HVIDEO  = 640,
  parameter int VVIDEO  = 480
) (
  input  logic                   i_pixel_clock,
  input  logic                   i_reset_n,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_video_on,
  input  logic [9:0]             i_hpos,
  input  logic [9:0]             i_vpos,
  input  logic [3*COLOR_W-1:0]   i_s_tdata,
  input  logic                   i_s_tvalid,
  output logic                   o_s_tready,
  input  logic                   i_s_tuser,
  input  logic                   i_s_tlast,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [COLOR_W-1:0]     o_red,
  output logic [COLOR_W-1:0]     o_green,
  output logic [COLOR_W-1:0]     o_blue,
  output logic                   o_synced,
  output logic                   o_underflow,
  output logic                   o_frame_err
`ifdef VGA_PIXEL_STREAM_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]            o_underflow_count
`endif
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam logic [9:0] H_LIM    = 10'(HVIDEO);
  localparam logic [9:0] V_LIM    = 10'(VVIDEO);
  localparam logic [9:0] LAST_COL = 10'(HVIDEO - 1);

  typedef enum logic [1:0] {
    SEEK,
    WAIT_FRAME,
    ACTIVE
  } state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               hsync_q, vsync_q;
  logic               synced_q;
  logic               underflow_q, underflow_d;
  logic               frame_err_q, frame_err_d;

  logic               in_video;
  logic               at_origin;
  logic               at_last_col;
  logic               underflow_now;
  logic               err_now;
  logic               s_tready;

  // Position bounds guard against a sync generator whose video_on disagrees with the active size.
  always_comb begin
    in_video      = i_video_on && (i_hpos < H_LIM) && (i_vpos < V_LIM);
    at_origin     = in_video && (i_hpos == 10'd0) && (i_vpos == 10'd0);
    at_last_col   = (i_hpos == LAST_COL);
    underflow_now = (state_q == ACTIVE) && in_video && !i_s_tvalid;
    err_now       = (state_q == ACTIVE) && in_video && i_s_tvalid &&
                    ((i_s_tuser != at_origin) || (i_s_tlast != at_last_col));
  end

  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      SEEK:       s_tready = !(i_s_tvalid && i_s_tuser);
      WAIT_FRAME: s_tready = at_origin;
      ACTIVE:     s_tready = in_video && !err_now;
      default:    s_tready = 1'b0;
    endcase
    if (!i_reset_n) begin
      s_tready = 1'b0;
    end
  end

  assign o_s_tready = s_tready;

  always_comb begin
    state_d     = state_q;
    pix_d       = '0;
    underflow_d = underflow_q;
    frame_err_d = frame_err_q;
    case (state_q)
      SEEK: begin
        if (i_s_tvalid && i_s_tuser) begin
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        // The held SOF beat is consumed exactly at raster (0,0); a vanished beat restarts the search.
        if (at_origin) begin
          if (i_s_tvalid) begin
            state_d = ACTIVE;
            pix_d   = i_s_tdata;
          end else begin
            state_d = SEEK;
          end
        end
      end
      ACTIVE: begin
        if (underflow_now) begin
          underflow_d = 1'b1;
          state_d     = SEEK;
        end else if (err_now) begin
          frame_err_d = 1'b1;
          state_d     = SEEK;
        end else if (in_video) begin
          pix_d = i_s_tdata;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_ff @(posedge i_pixel_clock) begin
    if (!i_reset_n) begin
      state_q     <= SEEK;
      pix_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      synced_q    <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      hsync_q     <= i_hsync;
      vsync_q     <= i_vsync;
      synced_q    <= (state_d == ACTIVE);
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;
  assign o_red       = pix_q[PIX_W-1 -: COLOR_W];
  assign o_green     = pix_q[2*COLOR_W-1 -: COLOR_W];
  assign o_blue      = pix_q[COLOR_W-1:0];
  assign o_synced    = synced_q;
  assign o_underflow = underflow_q;
  assign o_frame_err = frame_err_q;

`ifdef VGA_PIXEL_STREAM_UNDERFLOW_COUNT_EN
  logic [15:0] uf_count_q, uf_count_d;

  // One count per underflow event; blanked pixels that follow are not counted.
  always_comb begin
    uf_count_d = uf_count_q;
    if (underflow_now && (uf_count_q != 16'hFFFF)) begin
      uf_count_d = uf_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_pixel_clock) begin
    if (!i_reset_n) begin
      uf_count_q <= 16'd0;
    end else begin
      uf_count_q <= uf_count_d;
    end
  end

  assign o_underflow_count = uf_count_q;
`endif

endmodule
